// File: rtl/dieroll_pkg.sv
// Shared types and helpers for the die-roller control core.
// Optional LFSR result scrambling is enabled by defining DIEROLL_LFSR_EN.
package dieroll_pkg;

    localparam int FACE_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLE  = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam logic [1:0] SEL_D4  = 2'b00;
    localparam logic [1:0] SEL_D6  = 2'b01;
    localparam logic [1:0] SEL_D8  = 2'b10;
    localparam logic [1:0] SEL_D20 = 2'b11;

    function automatic logic [FACE_W-1:0] sides_decode(input logic [1:0] sel);
        logic [FACE_W-1:0] s;
        s = 5'd6;
        unique case (sel)
            SEL_D4:  s = 5'd4;
            SEL_D6:  s = 5'd6;
            SEL_D8:  s = 5'd8;
            SEL_D20: s = 5'd20;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dieroll_ctrl_debounce.sv
// Button synchronizer, debounce counter and registered press/release edges.
// Default build and DIEROLL_LFSR_EN build share this block unchanged.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_evt,
    output logic release_evt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic                   stable;
    logic                   stable_d;

    assign sync = sync_ff[SYNC_STAGES-1];

    // Metastability chain on the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff[0] <= btn_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    // Flip the stable level only after the input holds its new value long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // One-cycle registered edges of the stable level.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_d    <= 1'b0;
            press_evt   <= 1'b0;
            release_evt <= 1'b0;
        end else begin
            stable_d    <= stable;
            press_evt   <= stable & ~stable_d;
            release_evt <= ~stable & stable_d;
        end
    end

endmodule

// File: rtl/dieroll_ctrl.sv
// Roll-control core: debounced button, spin counter, animation and settle FSM.
// Define DIEROLL_LFSR_EN to scramble the captured result with a 16-bit LFSR.
module dieroll_ctrl
    import dieroll_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ANIM_DIV        = 250000,
    parameter int SETTLE_STEPS    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_raw,
    input  logic [1:0]        sides_sel,
    output logic [FACE_W-1:0] face,
    output logic              face_valid,
    output logic              rolling,
    output logic              done
);

    localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int STEP_W = (SETTLE_STEPS > 1) ? $clog2(SETTLE_STEPS) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ANIM_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SETTLE_STEPS - 1);

    logic press_evt;
    logic release_evt;

    state_t              state;
    state_t              state_n;
    logic [FACE_W-1:0]   sides_q;
    logic [FACE_W-1:0]   spin;
    logic [FACE_W-1:0]   result;
    logic [FACE_W-1:0]   result_n;
    logic [DIV_W-1:0]    div;
    logic [STEP_W-1:0]   step;
    logic                anim_tick;
    logic                latch;
    logic                capture;
    logic                finish;

    btn_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .press_evt  (press_evt),
        .release_evt(release_evt)
    );

    assign rolling   = (state == ROLLING) || (state == SETTLE);
    assign anim_tick = rolling && (div == DIV_LAST);

`ifdef DIEROLL_LFSR_EN
    logic [15:0] lfsr;
    logic [8:0]  acc;

    // Galois LFSR, x^16+x^14+x^13+x^11+1, free-running.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Offset spin by the LFSR and reduce modulo sides by restoring subtraction.
    always_comb begin
        acc = 9'(spin) - 9'd1 + 9'(lfsr[4:0]);
        for (int k = 3; k >= 0; k--) begin
            if (acc >= (9'(sides_q) << k)) begin
                acc = acc - (9'(sides_q) << k);
            end
        end
        result_n = 5'(acc + 9'd1);
    end
`else
    assign result_n = spin;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and event decode.
    always_comb begin
        state_n = state;
        latch   = 1'b0;
        capture = 1'b0;
        finish  = 1'b0;
        unique case (state)
            IDLE: begin
                if (press_evt) begin
                    state_n = ROLLING;
                    latch   = 1'b1;
                end
            end
            ROLLING: begin
                if (release_evt) begin
                    state_n = SETTLE;
                    capture = 1'b1;
                end
            end
            SETTLE: begin
                if (anim_tick && (step == STEP_LAST)) begin
                    state_n = SHOW;
                    finish  = 1'b1;
                end
            end
            SHOW: begin
                if (press_evt) begin
                    state_n = ROLLING;
                    latch   = 1'b1;
                end
            end
        endcase
    end

    // Die type, free-running spin and captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sides_q <= 5'd6;
            spin    <= 5'd1;
            result  <= 5'd1;
        end else begin
            spin <= (spin >= sides_q) ? 5'd1 : spin + 5'd1;
            if (latch) begin
                sides_q <= sides_decode(sides_sel);
            end
            if (capture) begin
                result <= result_n;
            end
        end
    end

    // Animation divider and settle step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= '0;
            step <= '0;
        end else begin
            if (!rolling || capture || anim_tick) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
            if (capture) begin
                step <= '0;
            end else if ((state == SETTLE) && anim_tick) begin
                step <= step + 1'b1;
            end
        end
    end

    // Displayed face, validity flag and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            face       <= 5'd1;
            face_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                face       <= result;
                face_valid <= 1'b1;
            end else begin
                if (anim_tick) begin
                    face <= (face >= sides_q) ? 5'd1 : face + 5'd1;
                end
                if (latch) begin
                    face_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dieroll_ctrl.sv
// Directed bench for dieroll_ctrl with a spin model and result scoreboard.
// Runs the default build (DIEROLL_LFSR_EN undefined).
module tb_dieroll_ctrl;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int AD = 2;
    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic [1:0] sides_sel = 2'b01;
    logic [4:0] face;
    logic       face_valid;
    logic       rolling;
    logic       done;

    dieroll_ctrl #(
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(D),
        .ANIM_DIV       (AD),
        .SETTLE_STEPS   (ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .sides_sel (sides_sel),
        .face      (face),
        .face_valid(face_valid),
        .rolling   (rolling),
        .done      (done)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [4:0] spin_m = 5'd1;
    logic [4:0] sides_m = 5'd6;
    int         latch_at = -1;
    logic [4:0] latch_val = 5'd6;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [4:0] exp_q[$];

    // Reference spin counter; die type follows the predicted latch edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            spin_m  <= 5'd1;
            sides_m <= 5'd6;
        end else begin
            spin_m <= (spin_m >= sides_m) ? 5'd1 : spin_m + 5'd1;
            if (cyc == latch_at) sides_m <= latch_val;
        end
    end

    function automatic logic [4:0] dec(input logic [1:0] s);
        case (s)
            2'b00:   return 5'd4;
            2'b01:   return 5'd6;
            2'b10:   return 5'd8;
            default: return 5'd20;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_press(input logic [1:0] sel, input bit from_show);
        int c;
        sides_sel = sel;
        c = cyc;
        latch_val = dec(sel);
        latch_at = c + S + D + 1;
        btn_raw = 1'b1;
        step_to(c + S + D + 1);
        check("pre_roll", rolling, 0);
        check("pre_fv", face_valid, from_show);
        step_to(c + S + D + 2);
        check("roll_rise", rolling, 1);
        check("fv_low", face_valid, 0);
    endtask

    task automatic do_release(input int mode);
        int c;
        logic [4:0] e;
        c = cyc;
        btn_raw = 1'b0;
        if (mode != 0) begin
            step_to(c + 5);
            btn_raw = 1'b1;
        end
        step_to(c + S + D + 1);
        exp_q.push_back(spin_m);
        check("still_rolling", rolling, 1);
        if (mode == 2) begin
            step_to(c + 10);
            rst = 1'b1;
            step_to(c + 11);
            rst = 1'b0;
            check("rst_face", face, 1);
            check("rst_fv", face_valid, 0);
            check("rst_rolling", rolling, 0);
            check("rst_done", done, 0);
            exp_q.delete();
            return;
        end
        step_to(c + S + D + 1 + ST * AD);
        check("settle_fv", face_valid, 0);
        check("settle_rolling", rolling, 1);
        check("settle_done", done, 0);
        step_to(c + S + D + 2 + ST * AD);
        check("show_fv", face_valid, 1);
        check("show_done", done, 1);
        check("show_rolling", rolling, 0);
        e = exp_q.pop_front();
        check("result", face, e);
        check("result_range", (face >= 5'd1) && (face <= sides_m), 1);
        step_to(c + S + D + 3 + ST * AD);
        check("done_pulse", done, 0);
        check("fv_hold", face_valid, 1);
        check("face_hold", face, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        bit seen;
        bit wrap;
        int bad;
        logic [4:0] prev;

        step_to(3);
        check("reset_face", face, 1);
        check("reset_fv", face_valid, 0);
        check("reset_rolling", rolling, 0);
        check("reset_done", done, 0);
        rst = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            btn_raw = 1'b1;
            for (int k = 0; k < 3; k++) begin
                step_to(cyc + 1);
                seen |= rolling;
            end
            btn_raw = 1'b0;
            for (int k = 0; k < 2; k++) begin
                step_to(cyc + 1);
                seen |= rolling;
            end
        end
        for (int k = 0; k < 12; k++) begin
            step_to(cyc + 1);
            seen |= rolling;
        end
        check("bounce_no_roll", seen, 0);

        r = cyc;
        do_press(2'b01, 1'b0);
        step_to(r + 20);
        do_release(0);

        do_press(2'b11, 1'b1);
        sides_sel = 2'b00;
        prev = face;
        wrap = 1'b0;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            step_to(cyc + 1);
            if (face != prev) begin
                if (!((face == prev + 5'd1) || (prev == 5'd20 && face == 5'd1)))
                    bad++;
                if (prev == 5'd20 && face == 5'd1) wrap = 1'b1;
            end
            prev = face;
        end
        check("anim_wrap", wrap, 1);
        check("anim_steps", bad, 0);
        do_release(0);

        do_press(2'b01, 1'b1);
        step_to(cyc + 6);
        do_release(1);

        btn_raw = 1'b0;
        step_to(cyc + 12);
        do_press(2'b01, 1'b1);
        step_to(cyc + 5);
        do_release(2);

        r = cyc;
        latch_val = dec(sides_sel);
        latch_at = r + S + D + 1;
        step_to(r + S + D + 1);
        check("post_rst_idle", rolling, 0);
        step_to(r + S + D + 2);
        check("post_rst_roll", rolling, 1);
        step_to(cyc + 4);
        do_release(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
